// File: rtl/hub75_rx.sv
// HUB75 receiver: synchronises panel-driver pins and rebuilds tagged column words.
// Define HUB75_RX_BLANK_MEAS_EN to add the on_cycles blank-off measurement output.
module hub75_rx #(
    parameter int unsigned COLS       = 64,
    parameter int unsigned ROWS       = 32,
    parameter int unsigned BITS       = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [11:0] rgb_in,
    input  logic        clk_in,
    input  logic        lat_in,
    input  logic        row_clk_in,
    input  logic        row_data_in,
    input  logic        blank_in,
    output logic        col_valid,
    input  logic        col_ready,
    output logic [11:0] col_data,
    output logic [7:0]  col_idx,
    output logic [7:0]  col_row,
    output logic [2:0]  col_bit,
    output logic        line_done,
    output logic [7:0]  line_count,
    output logic        err_len,
    output logic        err_ovf
`ifdef HUB75_RX_BLANK_MEAS_EN
    ,
    output logic [15:0] on_cycles
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned WW = 31;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e state;

    // Bit map: [11:0] rgb, [12] clk, [13] lat, [14] row_clk, [15] row_data, [16] blank
    logic [16:0] sync1, sync2;
    logic [15:0] sync3;
    logic        clk_ev, lat_ev, row_ev;

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            sync1  <= '0;
            sync2  <= '0;
            sync3  <= '0;
            clk_ev <= 1'b0;
            lat_ev <= 1'b0;
            row_ev <= 1'b0;
        end else begin
            sync1  <= {blank_in, row_data_in, row_clk_in, lat_in, clk_in, rgb_in};
            sync2  <= sync1;
            sync3  <= sync2[15:0];
            clk_ev <= sync2[12] & ~sync3[12];
            lat_ev <= sync2[13] & ~sync3[13];
            row_ev <= sync2[14] & ~sync3[14];
        end
    end

    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [WW-1:0] head;
    logic          fifo_full, pop, push_req, push;
    logic [7:0]    col_cnt, row, line_cols, row_next;
    logic [2:0]    bit_plane, bit_next;

    // Event pulses are one cycle late, so sync3 holds the data sampled with the edge.
    always_comb begin
        fifo_full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        col_valid = (wr_ptr != rd_ptr);
        head      = mem[rd_ptr[AW-1:0]];
        pop       = col_valid & col_ready;
        push_req  = (state == StRun) & clk_ev;
        push      = push_req & (~fifo_full | pop);
        line_cols = (push_req && col_cnt != 8'hFF) ? col_cnt + 8'd1 : col_cnt;
        if (sync3[15] || row == 8'(ROWS - 1)) begin
            row_next = 8'd0;
        end else begin
            row_next = row + 8'd1;
        end
        bit_next = (bit_plane == 3'(BITS - 1)) ? 3'd0 : bit_plane + 3'd1;
    end

    assign {col_data, col_idx, col_row, col_bit} = head;

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state      <= StIdle;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            col_cnt    <= 8'd0;
            row        <= 8'd0;
            bit_plane  <= 3'd0;
            line_done  <= 1'b0;
            line_count <= 8'd0;
            err_len    <= 1'b0;
            err_ovf    <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            line_done <= 1'b0;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {sync3[11:0], col_cnt, row, bit_plane};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (push_req && !push) begin
                err_ovf <= 1'b1;
            end
            case (state)
                StIdle: begin
                    if (row_ev && sync3[15]) begin
                        state     <= StRun;
                        row       <= 8'd0;
                        bit_plane <= 3'd0;
                        col_cnt   <= 8'd0;
                    end
                end
                StRun: begin
                    if (clk_ev && col_cnt != 8'hFF) begin
                        col_cnt <= col_cnt + 8'd1;
                    end
                    if (lat_ev) begin
                        line_count <= line_cols;
                        line_done  <= 1'b1;
                        col_cnt    <= 8'd0;
                        bit_plane  <= bit_next;
                        if (line_cols != 8'(COLS)) begin
                            err_len <= 1'b1;
                        end
                    end
                    // A row step restarts the plane sequence even if a latch coincides.
                    if (row_ev) begin
                        row       <= row_next;
                        bit_plane <= 3'd0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef HUB75_RX_BLANK_MEAS_EN
    logic [15:0] blank_cnt;

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            blank_cnt <= 16'd0;
            on_cycles <= 16'd0;
        end else if (state == StRun && lat_ev) begin
            on_cycles <= blank_cnt;
            blank_cnt <= sync2[16] ? 16'd0 : 16'd1;
        end else if (!sync2[16] && blank_cnt != 16'hFFFF) begin
            blank_cnt <= blank_cnt + 16'd1;
        end
    end
`else
    logic unused_blank;
    assign unused_blank = sync2[16];
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: pin-level stimulus, hand-computed column words and flags.
module tb_hub75_rx;

    logic        sys_clk;
    logic        rst;
    logic [11:0] rgb_in;
    logic        clk_in, lat_in, row_clk_in, row_data_in, blank_in;
    logic        col_valid, col_ready;
    logic [11:0] col_data;
    logic [7:0]  col_idx, col_row, line_count;
    logic [2:0]  col_bit;
    logic        line_done, err_len, err_ovf;
`ifdef HUB75_RX_BLANK_MEAS_EN
    logic [15:0] on_cycles;
`endif

    hub75_rx dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .rgb_in      (rgb_in),
        .clk_in      (clk_in),
        .lat_in      (lat_in),
        .row_clk_in  (row_clk_in),
        .row_data_in (row_data_in),
        .blank_in    (blank_in),
        .col_valid   (col_valid),
        .col_ready   (col_ready),
        .col_data    (col_data),
        .col_idx     (col_idx),
        .col_row     (col_row),
        .col_bit     (col_bit),
        .line_done   (line_done),
        .line_count  (line_count),
        .err_len     (err_len),
        .err_ovf     (err_ovf)
`ifdef HUB75_RX_BLANK_MEAS_EN
        ,
        .on_cycles   (on_cycles)
`endif
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    int          done_cnt = 0;
    int          done_ref;
    logic [31:0] got_q[$];

    // Record accepted words and latch pulses well away from the rising edge.
    always @(negedge sys_clk) begin
        #2;
        if (col_valid && col_ready) got_q.push_back({1'b0, col_data, col_idx, col_row, col_bit});
        if (line_done) done_cnt++;
    end

    function automatic logic [31:0] word(input logic [11:0] rgb, input logic [7:0] idx,
                                         input logic [7:0] r, input logic [2:0] b);
        return {1'b0, rgb, idx, r, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    task automatic clk_pulse(input logic [11:0] rgb);
        rgb_in = rgb;
        clk_in = 1'b1;
        tick(3);
        clk_in = 1'b0;
        tick(3);
    endtask

    task automatic lat_pulse();
        lat_in = 1'b1;
        tick(3);
        lat_in = 1'b0;
        tick(3);
    endtask

    task automatic row_pulse(input logic data);
        row_data_in = data;
        row_clk_in  = 1'b1;
        tick(3);
        row_clk_in  = 1'b0;
        tick(3);
        row_data_in = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        rgb_in = '0;
        clk_in = 1'b0;
        lat_in = 1'b0;
        row_clk_in = 1'b0;
        row_data_in = 1'b0;
        blank_in = 1'b1;
        col_ready = 1'b1;
        tick(4);
        chk("rst_valid", col_valid, 0);
        chk("rst_data", {col_data, col_idx, col_row, col_bit}, 0);
        chk("rst_done", line_done, 0);
        chk("rst_count", line_count, 0);
        chk("rst_errs", {err_len, err_ovf}, 0);
        rst = 1'b1;
        tick(2);

        // Full 64-column line on row 0 / plane 0, with pin-to-valid latency check.
        row_pulse(1'b1);
        got_q.delete();
        rgb_in = 12'hA5A;
        clk_in = 1'b1;
        tick(3);
        chk("lat_3cyc", col_valid, 0);
        tick(1);
        chk("lat_4cyc", col_valid, 1);
        clk_in = 1'b0;
        tick(3);
        for (int i = 1; i < 64; i++) clk_pulse(12'(12'hA5A + i));
        lat_pulse();
        chk("t1_nwords", got_q.size(), 64);
        for (int i = 0; i < 64; i++)
            if (i < got_q.size())
                chk("t1_word", got_q[i], word(12'(12'hA5A + i), 8'(i), 8'd0, 3'd0));
        chk("t1_done", done_cnt, 1);
        chk("t1_count", line_count, 64);
        chk("t1_errlen", err_len, 0);

        // Short line: 63 columns, plane 1.
        got_q.delete();
        for (int i = 0; i < 63; i++) clk_pulse(12'(12'h300 + i));
        lat_pulse();
        chk("t3_nwords", got_q.size(), 63);
        if (got_q.size() == 63) chk("t3_last", got_q[62], word(12'h33E, 8'd62, 8'd0, 3'd1));
        chk("t3_count", line_count, 63);
        chk("t3_errlen", err_len, 1);
        chk("t3_done", done_cnt, 2);

        // Plane stepping 2..7, wrap to 0, then row step clears plane.
        for (int j = 2; j < 8; j++) begin
            got_q.delete();
            clk_pulse(12'(12'h400 + j));
            lat_pulse();
            chk("t2_n", got_q.size(), 1);
            if (got_q.size() == 1)
                chk("t2_bit", got_q[0], word(12'(12'h400 + j), 8'd0, 8'd0, 3'(j)));
        end
        got_q.delete();
        clk_pulse(12'h7FF);
        chk("t2_wrap_n", got_q.size(), 1);
        if (got_q.size() == 1) chk("t2_wrap", got_q[0], word(12'h7FF, 8'd0, 8'd0, 3'd0));
        lat_pulse();
        row_pulse(1'b0);
        got_q.delete();
        clk_pulse(12'h123);
        chk("t2_row1_n", got_q.size(), 1);
        if (got_q.size() == 1) chk("t2_row1", got_q[0], word(12'h123, 8'd0, 8'd1, 3'd0));
        for (int r = 0; r < 31; r++) row_pulse(1'b0);
        got_q.delete();
        clk_pulse(12'h456);
        chk("t2_rowwrap_n", got_q.size(), 1);
        if (got_q.size() == 1) chk("t2_rowwrap", got_q[0], word(12'h456, 8'd1, 8'd0, 3'd0));
        chk("t2_errlen", err_len, 1);

        // Overflow: 6 columns into a 4-deep FIFO with the consumer stalled.
        lat_pulse();
        col_ready = 1'b0;
        got_q.delete();
        for (int i = 0; i < 4; i++) clk_pulse(12'(12'h100 + i));
        chk("t4_ovf_pre", err_ovf, 0);
        chk("t4_valid", col_valid, 1);
        chk("t4_head", {col_data, col_idx}, {12'h100, 8'd0});
        for (int i = 4; i < 6; i++) clk_pulse(12'(12'h100 + i));
        chk("t4_ovf", err_ovf, 1);
        chk("t4_noaccept", got_q.size(), 0);
        col_ready = 1'b1;
        tick(8);
        chk("t4_nwords", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got_q.size())
                chk("t4_word", got_q[i], word(12'(12'h100 + i), 8'(i), 8'd0, 3'd1));
        chk("t4_empty", col_valid, 0);
        done_ref = done_cnt;
        lat_pulse();
        chk("t4_count", line_count, 6);
        chk("t4_done", done_cnt, done_ref + 1);

        // Last column edge coincident with the latch edge.
        got_q.delete();
        for (int i = 0; i < 63; i++) clk_pulse(12'(12'h500 + i));
        done_ref = done_cnt;
        rgb_in = 12'h5FF;
        clk_in = 1'b1;
        lat_in = 1'b1;
        tick(3);
        clk_in = 1'b0;
        lat_in = 1'b0;
        tick(5);
        chk("t5_nwords", got_q.size(), 64);
        if (got_q.size() == 64) chk("t5_last", got_q[63], word(12'h5FF, 8'd63, 8'd0, 3'd2));
        chk("t5_count", line_count, 64);
        chk("t5_done", done_cnt, done_ref + 1);

        // Reset mid-line, then IDLE ignores clk/lat until a row_data=1 row clock.
        col_ready = 1'b0;
        for (int i = 0; i < 3; i++) clk_pulse(12'(12'h600 + i));
        chk("t6_pre_valid", col_valid, 1);
        done_ref = done_cnt;
        rst = 1'b0;
        tick(2);
        chk("t6_valid", col_valid, 0);
        chk("t6_data", {col_data, col_idx, col_row, col_bit}, 0);
        chk("t6_count", line_count, 0);
        chk("t6_errs", {err_len, err_ovf}, 0);
        rst = 1'b1;
        col_ready = 1'b1;
        got_q.delete();
        tick(2);
        lat_pulse();
        clk_pulse(12'h0AA);
        chk("t6_idle_done", done_cnt, done_ref);
        chk("t6_idle_words", got_q.size(), 0);
        row_pulse(1'b1);
        clk_pulse(12'h0BB);
        chk("t6_run_n", got_q.size(), 1);
        if (got_q.size() == 1) chk("t6_run", got_q[0], word(12'h0BB, 8'd0, 8'd0, 3'd0));

`ifdef HUB75_RX_BLANK_MEAS_EN
        lat_pulse();
        tick(2);
        blank_in = 1'b0;
        tick(100);
        blank_in = 1'b1;
        tick(4);
        lat_pulse();
        chk("meas_on", on_cycles, 100);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
HUB75 receiving end: samples the 12 colour lines plus clk_out/lat/row_clk/row_data/blank produced by the panel driver and reconstructs column words tagged with row and bit-plane. Used as a loopback checker / panel emulator on a second pin bank. Outputs a valid/ready column stream via a small FIFO, a per-latch line-commit status, and sticky error flags.

Parameters:
COLS, 64, expected clk_out edges per latch (per chain)
ROWS, 32, row-select positions; row counter wraps at ROWS
BITS, 8, bit planes per row; plane counter wraps at BITS
FIFO_DEPTH, 4, column FIFO entries (power of 2, >=2)

Ports:
sys_clk  in  1  system clock
rst  in  1  synchronous, active-low reset
rgb_in  in  12  {b4,g4,r4,b3,g3,r3,b2,g2,r2,b1,g1,r1} async pins
clk_in  in  1  HUB75 shift clock (async)
lat_in  in  1  latch (async)
row_clk_in  in  1  row shift-register clock (async)
row_data_in  in  1  row shift-register data (async)
blank_in  in  1  blank, high = display off (async)
col_valid  out  1  FIFO head valid
col_ready  in  1  consumer accepts head
col_data  out  12  captured colour bits
col_idx  out  8  column index 0..COLS-1 (saturates at 255)
col_row  out  8  current row
col_bit  out  3  current bit plane
line_done  out  1  1-cycle pulse on latch
line_count  out  8  columns counted in latched line
err_len  out  1  sticky: line_count != COLS at latch
err_ovf  out  1  sticky: column arrived with FIFO full

Behaviour:
- Reset (rst==0 at sys_clk edge): all outputs 0, counters 0, FIFO empty, sync chains cleared to 0. Reset mid-line discards partial line; no line_done.
- All 17 inputs pass through 2-flop synchronisers; a third register provides edge detect. Inputs require high/low >= 2 sys_clk.
- clk rising edge (s2 & !s3): capture rgb stage-2 value; push {rgb, col_cnt, row, bit} to FIFO; col_cnt += 1 (saturate 255). col_valid rises 4 cycles after pin edge.
- FIFO full on push: word dropped, err_ovf set. Push and pop same cycle when full: pop first, push succeeds.
- col_valid/ready: head held stable while valid & !ready; pop when both high.
- lat rising edge: line_count <= col_cnt; line_done pulse 1 cycle; err_len set if col_cnt != COLS; col_cnt <= 0; bit <= bit+1 (wrap BITS-1 -> 0). lat and clk edge same cycle: clk push uses old col_cnt and is counted in this line, then reset.
- row_clk rising edge: if row_data s2 == 1 then row <= 0 else row <= row+1 (wrap ROWS-1 -> 0); bit <= 0. Coincident lat edge: row update wins for bit (bit <= 0).
- FSM: IDLE (await first row_clk edge with row_data=1; clk/lat ignored) -> RUN. Any reset -> IDLE.
- Error flags clear only on reset.

Optional Feature:
HUB75_RX_BLANK_MEAS_EN: adds output on_cycles [15:0]: counts sys_clk cycles with synced blank==0 since the previous lat edge (saturating 0xFFFF), registered into on_cycles on each lat edge alongside line_done. Without macro: port absent, no counter logic.

Test Plan:
- Reset then row_clk with row_data=1, 64 clk pulses (rgb=12'hA5A+i), lat -> 64 FIFO words col_idx 0..63, row 0, bit 0; line_done once, line_count=64, err_len=0.
- 8 latches then row_clk with row_data=0 -> col_bit steps 0..7, next line row=1, bit=0; after 32 rows row wraps to 0.
- Line with 63 clk pulses then lat -> line_count=63, err_len=1 and stays 1.
- col_ready held 0, 6 clk pulses (FIFO_DEPTH=4) -> 4 words retained in order, err_ovf=1; release ready -> exactly 4 words drain.
- clk and lat edges on same cycle -> that word col_idx=63, line_count=64; rst low mid-line -> outputs 0, no line_done, FIFO empty.
- With HUB75_RX_BLANK_MEAS_EN: blank low 100 sys_clk between latches -> on_cycles=100 at line_done.
